// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared definitions for the EX->MEM skid pipeline register.
//   - default widths (scalar, vector lanes, register address, fault counter)
//   - payload_t: packed EX->MEM payload, the unit that is stored and parity protected
//   - state_t:   occupancy of the two-entry stage (EMPTY / ONE / TWO)
//   - calc_parity: even parity (XOR reduction) over a payload
package ex_mem_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_VLANES = 4;
  localparam int DEF_RA_W   = 5;
  localparam int DEF_FCNT_W = 8;

  typedef struct packed {
    logic [DEF_XLEN-1:0]            pc;
    logic [DEF_XLEN-1:0]            alu_res;
    logic [DEF_XLEN-1:0]            rd_data;
    logic [DEF_XLEN-1:0]            instr;
    logic [DEF_VLANES*DEF_XLEN-1:0] valu_res;
    logic [DEF_RA_W-1:0]            rd_addr;
    logic                           zero;
    logic                           reg_write;
    logic                           mem_to_reg;
    logic                           mem_read;
    logic                           mem_write;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic calc_parity(input payload_t p);
    return ^p;
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// ex_mem_slot: one storage entry of the EX->MEM stage.
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture d / d_parity and mark the entry valid
//   clr             : drop the entry (valid <= 0); wins over load, payload kept
//   d, d_parity     : incoming payload and its parity bit
//   q, q_parity     : stored payload and stored parity
//   q_valid         : entry holds a live beat
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  input  logic         d_parity,
  output logic [W-1:0] q,
  output logic         q_parity,
  output logic         q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '0;
      q_parity <= 1'b0;
      q_valid  <= 1'b0;
    end else begin
      if (clr) begin
        q_valid <= 1'b0;
      end else if (load) begin
        q_valid <= 1'b1;
      end
      // Clearing only invalidates; the payload bits stay as they were.
      if (load && !clr) begin
        q        <= d;
        q_parity <= d_parity;
      end
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX->MEM pipeline register with valid/ready handshake, a
// two-entry skid buffer (main + skid), flush and a parity fault monitor.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   flush_i                   : drop all held beats (and any incoming beat)
//   in_valid_i / in_ready_o   : upstream handshake; in_ready_o is registered
//   pc_i .. mem_write_i       : EX payload
//   out_valid_o / out_ready_i : downstream handshake
//   pc_o .. mem_write_o       : main-slot payload; write/read controls gated by out_valid_o
//   fault_inject_i            : flip stored alu_res[0] at capture, parity untouched
//   fault_clr_i               : clear fault_o / fault_cnt_o
//   fault_o, fault_cnt_o      : sticky parity error flag, saturating error count
module ex_mem_skid_reg
  import ex_mem_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int VLANES = DEF_VLANES,
  parameter int RA_W   = DEF_RA_W,
  parameter int FCNT_W = DEF_FCNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        alu_res_i,
  input  logic [XLEN-1:0]        rd_data_i,
  input  logic [XLEN-1:0]        instr_i,
  input  logic [VLANES*XLEN-1:0] valu_res_i,
  input  logic [RA_W-1:0]        rd_addr_i,
  input  logic                   zero_i,
  input  logic                   reg_write_i,
  input  logic                   mem_to_reg_i,
  input  logic                   mem_read_i,
  input  logic                   mem_write_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        pc_o,
  output logic [XLEN-1:0]        alu_res_o,
  output logic [XLEN-1:0]        rd_data_o,
  output logic [XLEN-1:0]        instr_o,
  output logic [VLANES*XLEN-1:0] valu_res_o,
  output logic [RA_W-1:0]        rd_addr_o,
  output logic                   zero_o,
  output logic                   mem_to_reg_o,
  output logic                   reg_write_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  input  logic                   fault_inject_i,
  input  logic                   fault_clr_i,
  output logic                   fault_o,
  output logic [FCNT_W-1:0]      fault_cnt_o
);

  state_t   state_reg, state_next;
  payload_t in_payload, cap_payload, main_d;
  payload_t main_payload, skid_payload;
  logic     in_parity, main_d_parity;
  logic     main_parity, skid_parity;
  logic     main_valid, skid_valid;
  logic     main_load, main_clr, main_from_skid;
  logic     skid_load, skid_clr;
  logic     in_fire, out_fire, fault_hit;

  logic              fault_reg;
  logic [FCNT_W-1:0] fault_cnt_reg;

  // Both handshake outputs come straight from slot flops, so ready never
  // depends combinationally on out_ready_i.
  assign in_ready_o  = ~skid_valid;
  assign out_valid_o = main_valid;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    in_payload            = '0;
    in_payload.pc         = pc_i;
    in_payload.alu_res    = alu_res_i;
    in_payload.rd_data    = rd_data_i;
    in_payload.instr      = instr_i;
    in_payload.valu_res   = valu_res_i;
    in_payload.rd_addr    = rd_addr_i;
    in_payload.zero       = zero_i;
    in_payload.reg_write  = reg_write_i;
    in_payload.mem_to_reg = mem_to_reg_i;
    in_payload.mem_read   = mem_read_i;
    in_payload.mem_write  = mem_write_i;
  end

  // Parity is taken over the clean payload; the injected flip happens after,
  // so an injected beat always carries a parity mismatch.
  assign in_parity = calc_parity(in_payload);

  always_comb begin
    cap_payload            = in_payload;
    cap_payload.alu_res[0] = in_payload.alu_res[0] ^ fault_inject_i;
  end

  assign main_d        = main_from_skid ? skid_payload : cap_payload;
  assign main_d_parity = main_from_skid ? skid_parity  : in_parity;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush_i) begin
      state_next = EMPTY;
      main_clr   = 1'b1;
      skid_clr   = 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_load  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load  = 1'b1;
            state_next = TWO;
          end else if (out_fire) begin
            main_clr   = 1'b1;
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready_o is low here, so only a drain can happen.
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_next     = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  ex_mem_slot #(.W(PAYLOAD_W)) u_main (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (main_load),
    .clr      (main_clr),
    .d        (main_d),
    .d_parity (main_d_parity),
    .q        (main_payload),
    .q_parity (main_parity),
    .q_valid  (main_valid)
  );

  ex_mem_slot #(.W(PAYLOAD_W)) u_skid (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (skid_load),
    .clr      (skid_clr),
    .d        (cap_payload),
    .d_parity (in_parity),
    .q        (skid_payload),
    .q_parity (skid_parity),
    .q_valid  (skid_valid)
  );

  // Checked only when the beat is consumed, so a stalled beat counts once.
  assign fault_hit = out_fire & (calc_parity(main_payload) != main_parity);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_reg     <= 1'b0;
      fault_cnt_reg <= '0;
    end else if (fault_hit) begin
      fault_reg <= 1'b1;
      if (fault_clr_i) begin
        fault_cnt_reg <= {{(FCNT_W-1){1'b0}}, 1'b1};
      end else if (fault_cnt_reg != {FCNT_W{1'b1}}) begin
        fault_cnt_reg <= fault_cnt_reg + {{(FCNT_W-1){1'b0}}, 1'b1};
      end
    end else if (fault_clr_i) begin
      fault_reg     <= 1'b0;
      fault_cnt_reg <= '0;
    end
  end

  assign fault_o     = fault_reg;
  assign fault_cnt_o = fault_cnt_reg;

  assign pc_o         = main_payload.pc;
  assign alu_res_o    = main_payload.alu_res;
  assign rd_data_o    = main_payload.rd_data;
  assign instr_o      = main_payload.instr;
  assign valu_res_o   = main_payload.valu_res;
  assign rd_addr_o    = main_payload.rd_addr;
  assign zero_o       = main_payload.zero;
  assign mem_to_reg_o = main_payload.mem_to_reg;
  assign reg_write_o  = main_payload.reg_write & main_valid;
  assign mem_read_o   = main_payload.mem_read  & main_valid;
  assign mem_write_o  = main_payload.mem_write & main_valid;

endmodule

// File: doc/ex_mem_skid_reg.md
# ex_mem_skid_reg

Parametrised EX→MEM pipeline register with a valid/ready handshake, a two-entry skid buffer, flush, and a parity-based fault monitor. It sits between the execute stage (scalar ALU plus VLANES-wide vector ALU) and the memory stage. It replaces the free-running stage register so that MEM can stall without a combinational ready path back into EX. Every held payload is parity-protected so that upsets in the stage register are detected and counted.

## Interface
- XLEN, 32: scalar datapath width (pc, ALU result, store data, instr).
- VLANES, 4: vector lanes; the vector result is VLANES*XLEN bits, lane k at [k*XLEN +: XLEN].
- RA_W, 5: destination register address width.
- FCNT_W, 8: fault counter width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  discard all held entries (branch/exception).
- in_valid_i / in_ready_o  in / out  1 / 1  upstream handshake.
- pc_i, alu_res_i, rd_data_i, instr_i  in  XLEN each  scalar payload.
- valu_res_i  in  VLANES*XLEN  vector ALU result.
- rd_addr_i  in  RA_W  destination register.
- zero_i, reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i  in  1 each  flags and controls.
- out_valid_o / out_ready_i  out / in  1 / 1  downstream handshake.
- pc_o, alu_res_o, rd_data_o, instr_o, valu_res_o, rd_addr_o, zero_o, mem_to_reg_o  out  matching widths  main-slot payload.
- reg_write_o, mem_read_o, mem_write_o  out  1 each  main-slot controls, ANDed with out_valid_o.
- fault_inject_i  in  1  test hook: at capture, flip bit 0 of the stored alu_res without updating the stored parity.
- fault_clr_i  in  1  clear fault_o and fault_cnt_o.
- fault_o  out  1  sticky parity-error flag.
- fault_cnt_o  out  FCNT_W  saturating count of faulty consumed beats.

## Operation
- Storage: a main slot and a skid slot. Each slot holds the full payload, its stored parity bit and a valid bit.
- Parity: even parity (XOR reduction) over the packed payload, computed on the input side at capture.
- States:
  - EMPTY: no valid slot.
  - ONE: main slot valid.
  - TWO: main and skid slots valid.
- Handshake terms: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Port mapping: in_ready_o = ~skid_valid (registered, never depends on out_ready_i); out_valid_o = main_valid.
- Transitions:
  - EMPTY: in_fire loads main, go to ONE.
  - ONE: in_fire & out_fire replaces main, stay in ONE. in_fire only loads skid, go to TWO. out_fire only, go to EMPTY.
  - TWO: in_fire cannot occur. out_fire moves skid into main, go to ONE.
- Flush: next state EMPTY and both valid bits cleared. Flush overrides a simultaneous in_fire; the incoming beat is dropped. An out_fire in the flush cycle still counts as consumed. Payload registers are not cleared by flush.
- Fault check on out_fire: recompute parity over the main payload and compare with the stored parity. On mismatch, set fault_o and increment fault_cnt_o, saturating at 2^FCNT_W-1. Only consumed beats are checked, so a stalled entry is counted at most once.
- fault_clr_i clears fault_o and fault_cnt_o. If a mismatch occurs in the same cycle, the new fault wins: fault_o=1, fault_cnt_o=1.

## Timing
- Reset values: state EMPTY; all payload outputs 0; out_valid_o 0; in_ready_o 1; fault_o 0; fault_cnt_o 0.
- Reset asserted mid-operation discards both slots immediately (asynchronously).
- Latency: a beat accepted at edge N appears on the outputs after edge N (one cycle) when the stage was EMPTY or ONE with out_fire.
- Throughput: one beat per cycle while out_ready_i=1.
- in_ready_o falls the cycle after the skid slot fills. It rises the cycle after the skid drains or after a flush.
- With out_ready_i held 0, exactly two beats are accepted; none is lost or duplicated.
- Fault flag and counter update on the edge ending the out_fire cycle.

## Structure
- Package ex_mem_pkg holds:
  - parameter defaults;
  - the packed payload struct typedef, parametrised by XLEN/VLANES/RA_W through localparams;
  - the state enum {EMPTY, ONE, TWO};
  - the function that computes the parity bit.
- One sub-module, ex_mem_slot: a payload + parity + valid register with load and clear enables, instantiated twice (main, skid).

## Test plan
- Reset then stream pc 0x100, 0x104, 0x108 with out_ready_i=1 → outputs show each pc one cycle after acceptance; in_ready_o stays 1; fault_cnt_o=0.
- out_ready_i=0, offer pc 0x200, 0x204, 0x208 → first two accepted, in_ready_o=0 from the third cycle; releasing out_ready_i yields 0x200, 0x204, then 0x208, in order.
- TWO state with mem_write_i=1 beats, assert flush_i with in_valid_i=1 → next cycle out_valid_o=0, mem_write_o=0, in_ready_o=1; the flushed beat never appears.
- fault_inject_i=1 on a beat with alu_res_i=0x0000_0010 → alu_res_o=0x0000_0011; on consumption fault_o=1 and fault_cnt_o=1. Stalling that beat 5 cycles before consuming it still gives count 1.
- Force fault_cnt_o to its maximum via 255 injected beats, then one more → stays 255. fault_clr_i coinciding with a new fault → fault_o=1, fault_cnt_o=1.
- Assert rst_i asynchronously mid-stream in state TWO → out_valid_o=0 and in_ready_o=1 before the next clock edge.
